dyn_pattern_det: RTL and testbench

Parametrised, run-time programmable serial pattern detector, the successor to the fixed-sequence `pattern_det`. It samples a qualified 1-bit stream and compares the most recent `pat_len_i` bits against a loadable pattern. Overlapping or non-overlapping match mode is selectable. Each match produces a one-cycle `pattern` pulse and increments a saturating match counter. It sits directly behind the serial source that drives `d_in`/`valid_i`, in place of `pattern_det`.

---
 rtl/dyn_pat_pkg.sv | 23 ++
 rtl/pat_match_cnt.sv | 39 +++
 rtl/dyn_pattern_det.sv | 127 ++++++++++++
 tb/tb_dyn_pattern_det.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dyn_pat_pkg.sv
// Shared definitions for the programmable serial pattern detector:
// default sizes, detector state encoding and the length clamp.
package dyn_pat_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ARMED = 2'd2
  } det_state_e;

  // Requested lengths beyond the history depth are treated as the full depth.
  function automatic int clamp_len(input int len, input int max_len);
    if (len > max_len) begin
      return max_len;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/pat_match_cnt.sv
// Saturating event counter with synchronous clear; a clear coinciding with
// an increment yields 1 so the concurrent event is never lost.
module pat_match_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear first, then count, holding at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? CNT_W'(1) : {CNT_W{1'b0}};
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dyn_pattern_det.sv
// Run-time programmable serial pattern detector: compares the newest
// len_q accepted bits against a loaded pattern and pulses on each match.
module dyn_pattern_det
  import dyn_pat_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_in,
  input  logic             valid_i,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_i,
  input  logic [LEN_W-1:0] pat_len_i,
  input  logic             overlap_i,
  input  logic             cnt_clr,
  output logic             pattern,
  output logic [CNT_W-1:0] match_count
);

  det_state_e       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             pattern_q, pattern_d;

  logic [PAT_W:0]   hist_ext_s;
  logic [PAT_W-1:0] hist_shift_s;
  logic [PAT_W-1:0] len_mask_s;
  logic [LEN_W-1:0] fill_inc_s;
  logic [LEN_W-1:0] len_load_s;
  logic             hit_s;

  // The extra top bit keeps the shift well-formed even for a one-bit history.
  assign hist_ext_s   = {hist_q, d_in};
  assign hist_shift_s = hist_ext_s[PAT_W-1:0];
  assign len_mask_s   = ~({PAT_W{1'b1}} << len_q);
  assign fill_inc_s   = (fill_q < len_q) ? (fill_q + LEN_W'(1)) : fill_q;
  assign len_load_s   = LEN_W'(clamp_len(int'(pat_len_i), PAT_W));
  assign hit_s        = (state_q != ST_IDLE) && (fill_inc_s == len_q) &&
                        (((hist_shift_s ^ pat_q) & len_mask_s) == {PAT_W{1'b0}});

  // Next-state, history/fill update and match decision.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = 1'b0;
    if (pat_load) begin
      // A bit offered in the load cycle is dropped so it cannot join the new pattern.
      pat_d   = pat_i;
      len_d   = len_load_s;
      ovl_d   = overlap_i;
      hist_d  = {PAT_W{1'b0}};
      fill_d  = {LEN_W{1'b0}};
      state_d = (len_load_s == {LEN_W{1'b0}}) ? ST_IDLE : ST_FILL;
    end else if (valid_i) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_FILL, ST_ARMED: begin
          hist_d = hist_shift_s;
          fill_d = fill_inc_s;
          if (hit_s) begin
            pattern_d = 1'b1;
            if (ovl_q) begin
              state_d = ST_ARMED;
            end else begin
              hist_d  = {PAT_W{1'b0}};
              fill_d  = {LEN_W{1'b0}};
              state_d = ST_FILL;
            end
          end else begin
            state_d = (fill_inc_s == len_q) ? ST_ARMED : ST_FILL;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Configuration, history, fill and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pat_q     <= {PAT_W{1'b0}};
      len_q     <= {LEN_W{1'b0}};
      ovl_q     <= 1'b1;
      hist_q    <= {PAT_W{1'b0}};
      fill_q    <= {LEN_W{1'b0}};
      pattern_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
    end
  end

  pat_match_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (pattern_d),
    .clr_i (cnt_clr),
    .cnt_o (match_count)
  );

  assign pattern = pattern_q;

endmodule

// File: tb/tb_dyn_pattern_det.sv
// Scoreboard bench for dyn_pattern_det: a 16-bit-counter instance and a
// 2-bit-counter instance share all stimulus.
module tb_dyn_pattern_det;

  logic        clk = 1'b0;
  logic        rst, d_in, valid_i, pat_load, overlap_i, cnt_clr;
  logic [7:0]  pat_i;
  logic [3:0]  pat_len_i;
  logic        pattern, pattern_s;
  logic [15:0] match_count;
  logic [1:0]  match_count_s;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        pat;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt2;

  always #5 clk = ~clk;

  dyn_pattern_det #(.PAT_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .valid_i(valid_i), .pat_load(pat_load),
    .pat_i(pat_i), .pat_len_i(pat_len_i), .overlap_i(overlap_i), .cnt_clr(cnt_clr),
    .pattern(pattern), .match_count(match_count)
  );

  dyn_pattern_det #(.PAT_W(8), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .d_in(d_in), .valid_i(valid_i), .pat_load(pat_load),
    .pat_i(pat_i), .pat_len_i(pat_len_i), .overlap_i(overlap_i), .cnt_clr(cnt_clr),
    .pattern(pattern_s), .match_count(match_count_s)
  );

  // One clock of stimulus; p is the expected pulse caused by this cycle.
  task automatic step(input logic r, input logic v, input logic d,
                      input logic ld, input logic clr, input logic p);
    rec_t e;
    rec_t o;
    rst = r; valid_i = v; d_in = d; pat_load = ld; cnt_clr = clr;
    if (r) begin
      m_cnt = 16'd0; m_cnt2 = 2'd0; e.pat = 1'b0;
    end else begin
      e.pat = p;
      if (clr) begin
        m_cnt  = p ? 16'd1 : 16'd0;
        m_cnt2 = p ? 2'd1 : 2'd0;
      end else if (p) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
      end
    end
    e.cnt = m_cnt; e.cnt2 = m_cnt2;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o.pat = pattern; o.cnt = match_count; o.cnt2 = match_count_s;
    if (pattern_s !== pattern) o.pat = 1'bx;
    obs_q.push_back(o);
    rst = 1'b0; valid_i = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] len, input logic ovl,
                      input logic v, input logic d);
    pat_i = p; pat_len_i = len; overlap_i = ovl;
    step(1'b0, v, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic feed(input logic [15:0] bits, input logic [15:0] hits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, bits[i], 1'b0, 1'b0, hits[i]);
  endtask

  task automatic test_reset();
    rec_t e, o;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o.pat !== e.pat) begin n_err++; $display("FAIL reset[%0d] pattern: got %b want %b", k, o.pat, e.pat); end
      n_cmp++; if (o.cnt !== e.cnt) begin n_err++; $display("FAIL reset[%0d] count: got %0d want %0d", k, o.cnt, e.cnt); end
      n_cmp++; if (o.cnt2 !== e.cnt2) begin n_err++; $display("FAIL reset[%0d] count2: got %0d want %0d", k, o.cnt2, e.cnt2); end
    end
  endtask

  task automatic test_overlap();
    rec_t e, o;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
    feed(16'b1011011, 16'b0001001, 7);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o.pat !== e.pat) begin n_err++; $display("FAIL overlap[%0d] pattern: got %b want %b", k, o.pat, e.pat); end
      n_cmp++; if (o.cnt !== e.cnt) begin n_err++; $display("FAIL overlap[%0d] count: got %0d want %0d", k, o.cnt, e.cnt); end
      n_cmp++; if (o.cnt2 !== e.cnt2) begin n_err++; $display("FAIL overlap[%0d] count2: got %0d want %0d", k, o.cnt2, e.cnt2); end
    end
    n_cmp++; if (match_count !== 16'd2) begin n_err++; $display("FAIL overlap final count: got %0d want 2", match_count); end
  endtask

  task automatic test_no_overlap();
    rec_t e, o;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    load(8'b0000_1011, 4'd4, 1'b0, 1'b0, 1'b0);
    feed(16'b1011011, 16'b0001000, 7);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o.pat !== e.pat) begin n_err++; $display("FAIL no_overlap[%0d] pattern: got %b want %b", k, o.pat, e.pat); end
      n_cmp++; if (o.cnt !== e.cnt) begin n_err++; $display("FAIL no_overlap[%0d] count: got %0d want %0d", k, o.cnt, e.cnt); end
      n_cmp++; if (o.cnt2 !== e.cnt2) begin n_err++; $display("FAIL no_overlap[%0d] count2: got %0d want %0d", k, o.cnt2, e.cnt2); end
    end
    n_cmp++; if (match_count !== 16'd1) begin n_err++; $display("FAIL no_overlap final count: got %0d want 1", match_count); end
  endtask

  task automatic test_valid_gaps();
    rec_t e, o;
    logic [6:0] bits = 7'b1011011;
    logic [6:0] hits = 7'b0001001;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
    for (int i = 6; i >= 0; i--) begin
      step(1'b0, 1'b1, bits[i], 1'b0, 1'b0, hits[i]);
      step(1'b0, 1'b0, ~bits[i], 1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o.pat !== e.pat) begin n_err++; $display("FAIL valid_gaps[%0d] pattern: got %b want %b", k, o.pat, e.pat); end
      n_cmp++; if (o.cnt !== e.cnt) begin n_err++; $display("FAIL valid_gaps[%0d] count: got %0d want %0d", k, o.cnt, e.cnt); end
      n_cmp++; if (o.cnt2 !== e.cnt2) begin n_err++; $display("FAIL valid_gaps[%0d] count2: got %0d want %0d", k, o.cnt2, e.cnt2); end
    end
    n_cmp++; if (match_count !== 16'd2) begin n_err++; $display("FAIL valid_gaps final count: got %0d want 2", match_count); end
  endtask

  task automatic test_reload();
    rec_t e, o;
    load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
    feed(16'b11, 16'b00, 2);
    load(8'b0000_0111, 4'd3, 1'b1, 1'b1, 1'b1);
    feed(16'b1111, 16'b0011, 4);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o.pat !== e.pat) begin n_err++; $display("FAIL reload[%0d] pattern: got %b want %b", k, o.pat, e.pat); end
      n_cmp++; if (o.cnt !== e.cnt) begin n_err++; $display("FAIL reload[%0d] count: got %0d want %0d", k, o.cnt, e.cnt); end
      n_cmp++; if (o.cnt2 !== e.cnt2) begin n_err++; $display("FAIL reload[%0d] count2: got %0d want %0d", k, o.cnt2, e.cnt2); end
    end
  endtask

  task automatic test_clamp_and_disable();
    rec_t e, o;
    load(8'hA5, 4'd15, 1'b1, 1'b0, 1'b0);
    feed(16'hA5, 16'h01, 8);
    load(8'hFF, 4'd0, 1'b1, 1'b0, 1'b0);
    feed(16'b1111, 16'b0000, 4);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o.pat !== e.pat) begin n_err++; $display("FAIL clamp[%0d] pattern: got %b want %b", k, o.pat, e.pat); end
      n_cmp++; if (o.cnt !== e.cnt) begin n_err++; $display("FAIL clamp[%0d] count: got %0d want %0d", k, o.cnt, e.cnt); end
      n_cmp++; if (o.cnt2 !== e.cnt2) begin n_err++; $display("FAIL clamp[%0d] count2: got %0d want %0d", k, o.cnt2, e.cnt2); end
    end
  endtask

  task automatic test_back_to_back();
    rec_t e, o;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    load(8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
    feed(16'hFF, 16'hFF, 8);
    n_cmp++; if (match_count_s !== 2'd3) begin n_err++; $display("FAIL saturate count2: got %0d want 3", match_count_s); end
    n_cmp++; if (match_count !== 16'd8) begin n_err++; $display("FAIL saturate count: got %0d want 8", match_count); end
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o.pat !== e.pat) begin n_err++; $display("FAIL back_to_back[%0d] pattern: got %b want %b", k, o.pat, e.pat); end
      n_cmp++; if (o.cnt !== e.cnt) begin n_err++; $display("FAIL back_to_back[%0d] count: got %0d want %0d", k, o.cnt, e.cnt); end
      n_cmp++; if (o.cnt2 !== e.cnt2) begin n_err++; $display("FAIL back_to_back[%0d] count2: got %0d want %0d", k, o.cnt2, e.cnt2); end
    end
  endtask

  task automatic test_reset_armed();
    rec_t e, o;
    load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
    feed(16'b1011, 16'b0001, 4);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    feed(16'b1011, 16'b0000, 4);
    load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
    feed(16'b1011, 16'b0001, 4);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o.pat !== e.pat) begin n_err++; $display("FAIL reset_armed[%0d] pattern: got %b want %b", k, o.pat, e.pat); end
      n_cmp++; if (o.cnt !== e.cnt) begin n_err++; $display("FAIL reset_armed[%0d] count: got %0d want %0d", k, o.cnt, e.cnt); end
      n_cmp++; if (o.cnt2 !== e.cnt2) begin n_err++; $display("FAIL reset_armed[%0d] count2: got %0d want %0d", k, o.cnt2, e.cnt2); end
    end
  endtask

  initial begin
    rst = 1'b0; d_in = 1'b0; valid_i = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
    overlap_i = 1'b1; pat_i = 8'h00; pat_len_i = 4'd0;
    m_cnt = 16'd0; m_cnt2 = 2'd0;
    test_reset();
    test_overlap();
    test_no_overlap();
    test_valid_gaps();
    test_reload();
    test_clamp_and_disable();
    test_back_to_back();
    test_reset_armed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
